// File: rtl/ifetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
// Handshake: the master raises imem_req with imem_addr and holds both steady until an edge
// samples imem_ack=1. imem_rdata is valid only in that cycle, and ack outside a request is ignored.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC and runs a req/ack read, then strobes IR_Write for one cycle.
// Define IFETCH_TIMEOUT_EN to abort a fetch after TIMEOUT_CYCLES WAIT cycles without ack.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic [31:0]        pc_in,
  ifetch_unit_if.master      imem,
  output logic [31:0]        ins,
  output logic               IR_Write,
  output logic [31:0]        pc_out,
  output logic               busy,
  output logic               fetch_err,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] eff_addr;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ifetch_unit: TIMEOUT_CYCLES must be in 1..255");
  end

  // A same-cycle pc_load redirects the fetch itself, not only the PC.
  assign eff_addr  = pc_load ? pc_in : pc_out;
  assign dbg_state = state;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc_out         <= RESET_PC;
      ins            <= '0;
      imem.imem_addr <= '0;
      imem.imem_req  <= 1'b0;
      IR_Write       <= 1'b0;
      fetch_err      <= 1'b0;
      busy           <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      fetch_err <= 1'b0;
      IR_Write  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            if (eff_addr[1:0] == 2'b00) begin
              imem.imem_addr <= eff_addr;
              imem.imem_req  <= 1'b1;
              pc_out         <= eff_addr;
              busy           <= 1'b1;
              state          <= S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
              wait_cnt       <= '0;
`endif
            end else begin
              fetch_err <= 1'b1;
              if (pc_load) pc_out <= pc_in;
            end
          end else if (pc_load) begin
            pc_out <= pc_in;
          end
        end

        S_WAIT: begin
          if (imem.imem_ack) begin
            ins           <= imem.imem_rdata;
            imem.imem_req <= 1'b0;
            IR_Write      <= 1'b1;
            pc_out        <= pc_out + 32'd4;
            state         <= S_DONE;
`ifdef IFETCH_TIMEOUT_EN
          end else if (wait_cnt == TO_LAST) begin
            // PC stays on the failed address so control can retry it.
            imem.imem_req <= 1'b0;
            fetch_err     <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          imem.imem_req <= 1'b0;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases, then randomized fetch traffic against a
// transaction-level model (PC value, last instruction, expected-instruction queue).
module tb_ifetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 4;

  logic        clk;
  logic        rst_n;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_in;
  logic [31:0] ins;
  logic        ir_write;
  logic [31:0] pc_out;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .imem       (bus.master),
    .ins        (ins),
    .IR_Write   (ir_write),
    .pc_out     (pc_out),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One IDLE-state request, followed to completion. delay = WAIT cycles before ack.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] tgt,
                        input int delay, input logic [31:0] rdv);
    logic [31:0] addr;
    addr        = ld ? tgt : exp_pc;
    fetch_start = st;
    pc_load     = ld;
    pc_in       = tgt;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_in       = $urandom();

    if (!st) begin
      if (ld) exp_pc = tgt;
      chk("idle_pc", pc_out, exp_pc);
      chk("idle_req", 32'(bus.imem_req), 32'd0);
      chk("idle_err", 32'(fetch_err), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      return;
    end

    if (addr[1:0] != 2'b00) begin
      if (ld) exp_pc = tgt;
      chk("mis_err", 32'(fetch_err), 32'd1);
      chk("mis_req", 32'(bus.imem_req), 32'd0);
      chk("mis_irw", 32'(ir_write), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_pc", pc_out, exp_pc);
      chk("mis_ins_hold", ins, exp_ins);
      @(posedge clk); #1;
      chk("mis_err_clr", 32'(fetch_err), 32'd0);
      chk("mis_irw2", 32'(ir_write), 32'd0);
      return;
    end

    chk("req_up", 32'(bus.imem_req), 32'd1);
    chk("req_addr", bus.imem_addr, addr);
    chk("req_busy", 32'(busy), 32'd1);
    chk("req_pc", pc_out, addr);
    chk("req_irw", 32'(ir_write), 32'd0);

    for (int c = 0; c <= delay; c++) begin
      bus.imem_ack   = (c == delay);
      bus.imem_rdata = (c == delay) ? rdv : $urandom();
      fetch_start    = 1'($urandom_range(0, 1));
      pc_load        = 1'($urandom_range(0, 1));
      if (c == delay) exp_q.push_back(rdv);
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      fetch_start  = 1'b0;
      pc_load      = 1'b0;
      if (c == delay) begin
        exp_pc  = addr + 32'd4;
        exp_ins = exp_q.pop_front();
        chk("ack_irw", 32'(ir_write), 32'd1);
        chk("ack_ins", ins, exp_ins);
        chk("ack_req", 32'(bus.imem_req), 32'd0);
        chk("ack_pc", pc_out, exp_pc);
        chk("ack_busy", 32'(busy), 32'd1);
        chk("ack_err", 32'(fetch_err), 32'd0);
        @(posedge clk); #1;
        chk("done_irw", 32'(ir_write), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_pc", pc_out, exp_pc);
        chk("done_ins", ins, exp_ins);
        return;
      end
`ifdef IFETCH_TIMEOUT_EN
      if (c == TO - 1) begin
        exp_pc = addr;
        chk("to_req", 32'(bus.imem_req), 32'd0);
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_irw", 32'(ir_write), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_pc", pc_out, exp_pc);
        @(posedge clk); #1;
        chk("to_err_clr", 32'(fetch_err), 32'd0);
        chk("to_irw2", 32'(ir_write), 32'd0);
        return;
      end
`endif
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", bus.imem_addr, addr);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_irw", 32'(ir_write), 32'd0);
      chk("wait_err", 32'(fetch_err), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tgt;
    int          r;
    rst_n          = 1'b0;
    fetch_start    = 1'b0;
    pc_load        = 1'b0;
    pc_in          = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    exp_pc         = RST_PC;
    exp_ins        = '0;
    #2;
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_ins", ins, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_irw", 32'(ir_write), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait, wait states, branch redirect, misaligned target, PC wrap
    run_op(1'b0, 1'b1, 32'd0, 0, 32'h8C22_0004);
    chk("zw_pc", pc_out, 32'd4);
    run_op(1'b0, 1'b1, 32'd0, 3, 32'h1234_5678);
    run_op(1'b1, 1'b1, 32'h40, 0, 32'hCAFE_0001);
    chk("br_pc", pc_out, 32'h44);
    run_op(1'b1, 1'b1, 32'h42, 0, 32'h0);
    chk("mis_pc_42", pc_out, 32'h42);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFC, 0, 32'h0);
    run_op(1'b0, 1'b1, 32'h0, 1, 32'hA5A5_5A5A);
    chk("wrap_pc", pc_out, 32'h0);

`ifdef IFETCH_TIMEOUT_EN
    run_op(1'b1, 1'b1, 32'h80, TO + 2, 32'h0);
    chk("to_pc_hold", pc_out, 32'h80);
    run_op(1'b0, 1'b1, 32'h0, 0, 32'hBEEF_0080);
    chk("retry_pc", pc_out, 32'h84);
    run_op(1'b0, 1'b1, 32'h0, TO - 1, 32'h0BAD_F00D);
`endif

    // reset during WAIT: request must drop without a clock edge
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    chk("mid_req_up", 32'(bus.imem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_pc", pc_out, RST_PC);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ins", ins, 32'd0);
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n          = 1'b1;
    exp_pc         = RST_PC;
    exp_ins        = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_irw", 32'(ir_write), 32'd0);
      chk("post_rst_req", 32'(bus.imem_req), 32'd0);
    end
    bus.imem_ack = 1'b0;

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      r   = $urandom_range(0, 9);
      tgt = $urandom();
      if (r == 3 || (r < 2 && $urandom_range(0, 3) == 0)) begin
        if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
      end else begin
        tgt[1:0] = 2'b00;
      end
      case (r)
        0, 1:    run_op(1'b1, 1'b0, tgt, 0, 32'h0);
        2:       run_op(1'b0, 1'b0, tgt, 0, 32'h0);
        3:       run_op(1'b1, 1'b1, tgt, 0, 32'h0);
        default: run_op(($urandom_range(0, 9) < 3), 1'b1, tgt,
                        $urandom_range(0, 5), $urandom());
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so a stuck bench still reports.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
